// File: rtl/registro_deserializador_if.sv
`default_nettype none
// ============================================================================
// Module      : registro_deserializador_if
// Description : Serial receive bus for registro_deserializador.
//               master : the serial source and the word consumer.
//               slave  : the deserializer.
//   ENB   bit qualifier           DIR   bit order (1 = MSB-first)
//   S_IN  serial data, idle 0     ACK   consumer acknowledge
//   Q     delivered word          VALID word on Q is unacknowledged
//   PERR  parity error for Q      OVR   sticky overrun
//   BUSY  frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface registro_deserializador_if #(
  parameter int WIDTH = 4
);
  logic             ENB;
  logic             DIR;
  logic             S_IN;
  logic             ACK;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             PERR;
  logic             OVR;
  logic             BUSY;

  modport master (
    output ENB, DIR, S_IN, ACK,
    input  Q, VALID, PERR, OVR, BUSY
  );

  modport slave (
    input  ENB, DIR, S_IN, ACK,
    output Q, VALID, PERR, OVR, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/registro_deserializador.sv
`default_nettype none
// ============================================================================
// Module      : registro_deserializador
// Description : Serial-to-parallel receiver. A start bit (S_IN=1 while idle)
//               opens a frame of WIDTH data bits plus an optional even-parity
//               bit; the assembled word is delivered on Q with a VALID/ACK
//               handshake. Unacknowledged words cause an overrun (OVR).
//   clk  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : registro_deserializador_if.slave (ENB, DIR, S_IN, ACK in;
//          Q, VALID, PERR, OVR, BUSY out)
// Revision    : 1.0 - initial release
// ============================================================================
module registro_deserializador #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                        clk,
  input  logic                        RST,
  registro_deserializador_if.slave    bus
);

  localparam int                  c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_next;
  logic [WIDTH-1:0]   w_shift_in;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic               r_dir;
  logic               w_dir_next;
  logic               w_done;
  logic [WIDTH-1:0]   w_word;
  logic               w_perr;

  logic [WIDTH-1:0]   r_q;
  logic               r_valid;
  logic               r_perr;
  logic               r_ovr;

  // Shift register contents after taking in the current S_IN under the
  // direction latched with the start bit.
  assign w_shift_in = r_dir ? {r_shift[WIDTH-2:0], bus.S_IN}
                            : {bus.S_IN, r_shift[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // Next-state / frame assembly
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_dir_next   = r_dir;
    w_done       = 1'b0;
    w_word       = w_shift_in;
    w_perr       = 1'b0;

    if (bus.ENB) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.S_IN) begin
            w_state_next = ST_DATA;
            w_dir_next   = bus.DIR;
            w_cnt_next   = '0;
            w_shift_next = '0;
          end
        end
        ST_DATA: begin
          w_shift_next = w_shift_in;
          w_cnt_next   = r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            w_cnt_next = '0;
            if (PARITY_EN != 0) begin
              w_state_next = ST_PAR;
            end else begin
              w_state_next = ST_IDLE;
              w_done       = 1'b1;
              w_word       = w_shift_in;
            end
          end
        end
        ST_PAR: begin
          // Even parity: any odd total of ones across data+parity is an error.
          w_state_next = ST_IDLE;
          w_done       = 1'b1;
          w_word       = r_shift;
          w_perr       = (^r_shift) ^ bus.S_IN;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_dir   <= w_dir_next;
    end
  end

  // --------------------------------------------------------------------------
  // Delivery and handshake. A completion always takes priority over a plain
  // acknowledge; an ACK coinciding with completion lets the new word replace
  // the old one instead of overrunning.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_q     <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || bus.ACK) begin
        r_q     <= w_word;
        r_perr  <= w_perr;
        r_valid <= 1'b1;
      end else begin
        r_ovr   <= 1'b1;
      end
    end else if (bus.ACK && r_valid) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign bus.Q     = r_q;
  assign bus.VALID = r_valid;
  assign bus.PERR  = r_perr;
  assign bus.OVR   = r_ovr;
  assign bus.BUSY  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_registro_deserializador.sv
`default_nettype none
// ============================================================================
// Module      : tb_registro_deserializador
// Description : Self-checking bench for registro_deserializador (WIDTH=4,
//               PARITY_EN=1). A frame-level reference model collects the
//               enabled bits of each frame and builds the word arithmetically;
//               a compare process checks every output on every falling edge.
//               Directed frames pin the model with literal expectations, then
//               randomized traffic runs against the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_registro_deserializador;

  localparam int WIDTH     = 4;
  localparam int PARITY_EN = 1;
  localparam int FRAME_LEN = WIDTH + PARITY_EN;  // bits after the start bit

  logic clk = 1'b0;
  logic rst = 1'b1;

  registro_deserializador_if #(.WIDTH(WIDTH)) bus ();

  registro_deserializador #(
    .WIDTH     (WIDTH),
    .PARITY_EN (PARITY_EN)
  ) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a frame is "start bit, then FRAME_LEN enabled bits".
  // --------------------------------------------------------------------------
  bit             m_active = 0;
  bit             m_dir    = 0;
  bit             m_bits[$];
  logic [WIDTH-1:0] m_q    = '0;
  bit             m_valid  = 0;
  bit             m_perr   = 0;
  bit             m_ovr    = 0;

  function automatic logic [WIDTH-1:0] frame_word(input bit dir);
    logic [WIDTH-1:0] w = '0;
    // MSB-first: first data bit lands in the top position.
    for (int i = 0; i < WIDTH; i++) begin
      if (dir) w[WIDTH-1-i] = m_bits[i];
      else     w[i]         = m_bits[i];
    end
    return w;
  endfunction

  function automatic bit frame_perr();
    bit p = 0;
    for (int i = 0; i < FRAME_LEN; i++) p ^= m_bits[i];
    return (PARITY_EN != 0) ? p : 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit               done;
    logic [WIDTH-1:0] word;
    bit               perr;
    if (rst) begin
      m_active = 0; m_dir = 0; m_bits.delete();
      m_q = '0; m_valid = 0; m_perr = 0; m_ovr = 0;
    end else begin
      done = 0; word = '0; perr = 0;
      if (bus.ENB) begin
        if (!m_active) begin
          if (bus.S_IN) begin
            m_active = 1;
            m_dir    = bus.DIR;
            m_bits.delete();
          end
        end else begin
          m_bits.push_back(bus.S_IN);
          if (m_bits.size() == FRAME_LEN) begin
            done     = 1;
            word     = frame_word(m_dir);
            perr     = frame_perr();
            m_active = 0;
          end
        end
      end
      if (done) begin
        if (!m_valid || bus.ACK) begin
          m_q = word; m_perr = perr; m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (bus.ACK && m_valid) begin
        m_valid = 0; m_ovr = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("q",     32'(bus.Q),     32'(m_q));
    check("valid", 32'(bus.VALID), 32'(m_valid));
    check("perr",  32'(bus.PERR),  32'(m_perr));
    check("ovr",   32'(bus.OVR),   32'(m_ovr));
    check("busy",  32'(bus.BUSY),  32'(m_active));
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step(input logic e, input logic d, input logic s, input logic a);
    bus.ENB  = e;
    bus.DIR  = d;
    bus.S_IN = s;
    bus.ACK  = a;
    @(posedge clk);
    #1;
  endtask

  // seq[5] is the first bit sent (the start bit). ACK is raised only on the
  // final (completion) edge when ack_last is set.
  task automatic send_frame(input logic d, input logic [5:0] seq, input logic ack_last,
                            input string tag);
    for (int i = 5; i >= 0; i--) begin
      step(1'b1, d, seq[i], (i == 0) ? ack_last : 1'b0);
      if (i != 0) check({tag, "_busy_mid"}, 32'(bus.BUSY), 32'd1);
    end
    check({tag, "_busy_end"}, 32'(bus.BUSY), 32'd0);
  endtask

  task automatic ack_pulse();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.ENB = 0; bus.DIR = 0; bus.S_IN = 0; bus.ACK = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q",     32'(bus.Q),     32'd0);
    check("rst_valid", 32'(bus.VALID), 32'd0);
    check("rst_busy",  32'(bus.BUSY),  32'd0);
    rst = 0;
    step(0, 0, 0, 0);

    // 1: MSB-first
    send_frame(1'b1, 6'b110111, 1'b0, "t1");
    check("t1_q",     32'(bus.Q),     32'b1011);
    check("t1_valid", 32'(bus.VALID), 32'd1);
    check("t1_perr",  32'(bus.PERR),  32'd0);
    ack_pulse();

    // 2: LSB-first
    send_frame(1'b0, 6'b110111, 1'b0, "t2");
    check("t2_q",    32'(bus.Q),    32'b1101);
    check("t2_perr", 32'(bus.PERR), 32'd0);
    ack_pulse();

    // 3: parity error
    send_frame(1'b1, 6'b100001, 1'b0, "t3");
    check("t3_q",    32'(bus.Q),    32'b0000);
    check("t3_perr", 32'(bus.PERR), 32'd1);
    ack_pulse();

    // 4: ENB gap after the second data bit
    step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, ~bus.S_IN, 0);
      check("t4_busy_gap", 32'(bus.BUSY), 32'd1);
    end
    step(1, 0, 1, 0); step(1, 0, 1, 0);
    check("t4_busy_par", 32'(bus.BUSY), 32'd1);
    step(1, 0, 1, 0);
    check("t4_q",    32'(bus.Q),    32'b1011);
    check("t4_busy", 32'(bus.BUSY), 32'd0);
    ack_pulse();

    // 5: overrun, clear, then ACK coinciding with completion
    send_frame(1'b1, 6'b110111, 1'b0, "t5a");
    send_frame(1'b1, 6'b101100, 1'b0, "t5b");
    check("t5_ovr_q",     32'(bus.Q),     32'b1011);
    check("t5_ovr",       32'(bus.OVR),   32'd1);
    check("t5_ovr_valid", 32'(bus.VALID), 32'd1);
    ack_pulse();
    check("t5_clr_valid", 32'(bus.VALID), 32'd0);
    check("t5_clr_ovr",   32'(bus.OVR),   32'd0);
    send_frame(1'b1, 6'b110111, 1'b0, "t5c");
    send_frame(1'b1, 6'b101100, 1'b1, "t5d");
    check("t5_ack_q",     32'(bus.Q),     32'b0110);
    check("t5_ack_valid", 32'(bus.VALID), 32'd1);
    check("t5_ack_ovr",   32'(bus.OVR),   32'd0);

    // 6: asynchronous reset mid-frame
    step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 0, 0);
    #2 rst = 1;
    #1;
    check("t6_rst_q",     32'(bus.Q),     32'd0);
    check("t6_rst_valid", 32'(bus.VALID), 32'd0);
    check("t6_rst_busy",  32'(bus.BUSY),  32'd0);
    #2 rst = 0;
    bus.ENB = 0;
    @(posedge clk); #1;
    send_frame(1'b1, 6'b110111, 1'b0, "t6");
    check("t6_q",    32'(bus.Q),    32'b1011);
    check("t6_perr", 32'(bus.PERR), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/registro_deserializador.md
Name: registro_deserializador

Overview:
- Serial-to-parallel receiver; the other end of the 4-bit shift register's serial output (S_OUT).
- Detects a start bit, then shifts in WIDTH data bits in the order selected by DIR.
- Optionally checks one even-parity bit.
- Presents the assembled word on Q with a VALID/ACK handshake, and flags parity errors and overruns.

Parameters:
- WIDTH, 4, number of data bits per frame (≥2).
- PARITY_EN, 1, 1 = frame carries one even-parity bit after the data; 0 = no parity bit, PERR tied 0.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- ENB  input  1  bit-qualifier; S_IN is consumed only on edges where ENB=1.
- DIR  input  1  bit order, sampled with the start bit: 1 = MSB-first (shift left, new bit enters Q[0]); 0 = LSB-first (shift right, new bit enters Q[WIDTH-1]).
- S_IN  input  1  serial data line; idle level 0.
- ACK  input  1  consumer acknowledge; clears VALID.
- Q  output  WIDTH  last delivered word.
- VALID  output  1  word on Q is new and unacknowledged.
- PERR  output  1  parity error for the word on Q.
- OVR  output  1  sticky overrun flag.
- BUSY  output  1  frame in progress.

Behaviour:
- Reset: RST=1 forces, immediately and independently of clk:
  - state=IDLE; Q=0, VALID=0, PERR=0, OVR=0, BUSY=0.
  - shift register, bit counter and latched DIR cleared.
  - A reset mid-frame discards the partial frame.
- ENB=0: no state, counter or shift change.
  - ACK is still honoured with ENB=0.
- States:
  - IDLE: on an edge with ENB=1 and S_IN=1 (start bit), latch DIR, clear counter, go to DATA, BUSY=1. S_IN=0 stays IDLE.
  - DATA: each enabled edge shifts S_IN into the internal shift register per the latched DIR and increments the counter. The WIDTH-th data bit goes to PAR if PARITY_EN=1, else completes.
  - PAR: the next enabled edge samples the parity bit and completes.
- Completion edge: return to IDLE, BUSY=0 from the following cycle.
  - Frame length is 1+WIDTH+PARITY_EN enabled cycles.
  - VALID, Q and PERR are visible right after the completion edge; no extra latency.
  - A start bit can be accepted on the edge immediately after completion; back-to-back frames are allowed.
- Parity: PERR = XOR of the data bits and the parity bit. Even parity, so 1 means error.
- Delivery on the completion edge:
  - VALID=0: load Q and PERR, set VALID=1.
  - VALID=1 and ACK=1 on the same edge: load the new word; VALID stays 1; OVR unchanged.
  - VALID=1 and ACK=0: discard the new word; Q and PERR hold; OVR=1.
- ACK: an edge with ACK=1 and no simultaneous completion clears VALID and OVR. ACK while VALID=0 has no effect.
- DIR changes mid-frame are ignored; the latched value applies.
- Q never changes except at delivery or reset. Internal shifting is not visible on Q.

Test Plan (WIDTH=4, PARITY_EN=1):
1. RST pulse, then ENB=1, DIR=1, S_IN=1,1,0,1,1,1 on 6 edges -> after edge 6: Q=1011, VALID=1, PERR=0, BUSY=0. BUSY=1 from edge 1 to edge 5.
2. DIR=0, same S_IN sequence 1,1,0,1,1,1 -> Q=1101, VALID=1, PERR=0.
3. DIR=1, S_IN=1,0,0,0,0,1 -> Q=0000, VALID=1, PERR=1.
4. Scenario 1 with ENB=0 for 3 cycles after the second data bit -> Q=1011, completion 3 cycles later, BUSY held 1 through the gap, no corruption.
5. Overrun:
   - Deliver 1011 and hold ACK=0, then send DIR=1, S_IN=1,0,1,1,0,0 -> Q stays 1011, OVR=1, VALID=1.
   - Then ACK=1 for one edge -> VALID=0, OVR=0.
   - Repeat the second frame with ACK=1 on its completion edge while VALID=1 -> Q=0110, VALID=1, OVR=0.
6. Assert RST asynchronously, between edges, after 2 data bits -> outputs 0 immediately, before the next edge. Release RST, then send frame 1 -> Q=1011, PERR=0.
